// File: rtl/cpu_mem_responder_pkg.sv
// Shared definitions for the MIPS memory responder: MMIO register map and STATUS layout.
package cpu_mem_responder_pkg;

  // Word offset inside the 16-byte MMIO window (addr[3:2]).
  typedef enum logic [1:0] {
    RegCycle   = 2'd0,
    RegConsole = 2'd1,
    RegStatus  = 2'd2,
    RegDrops   = 2'd3
  } mmio_reg_e;

  function automatic logic [31:0] status_word(input logic [2:0] cnt, input logic empty,
                                              input logic full);
    return {27'b0, cnt, empty, full};
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// Console byte FIFO: push/pop with count, head data is zero whenever the FIFO is empty.
module tx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o,
  output logic [WIDTH-1:0] head_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; the empty flag masks stale entries.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/cpu_mem_responder.sv
// Unified instruction/data RAM for the single-cycle MIPS core plus an MMIO window holding a
// cycle counter, a console TX FIFO with valid/ready drain, and a dropped-byte counter.
module cpu_mem_responder
  import cpu_mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] MMIO_BASE  = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC,
  output logic [31:0] Instruction,
  input  logic [31:0] Address,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Write_data,
  input  logic [3:0]  Write_strb,
  output logic [31:0] Read_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam int unsigned Words = 2 ** ADDR_WIDTH;
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);

  logic [31:0] ram_q [Words];

  logic [31:0] cycle_q, cycle_d;
  logic [31:0] drops_q, drops_d;

  logic            fetch_hit, data_ram_hit, mmio_hit;
  mmio_reg_e       reg_sel;
  logic            console_wr, drops_clr, push, pop, drop;
  logic            fifo_full, fifo_empty;
  logic [CntW-1:0] fifo_count;
  logic [7:0]      fifo_head;
  logic [31:0]     count_ext;
  logic [2:0]      status_cnt;
  logic            unused_addr_lsbs;

  assign fetch_hit    = (PC[31:ADDR_WIDTH+2] == '0);
  assign data_ram_hit = (Address[31:ADDR_WIDTH+2] == '0);
  assign mmio_hit     = (Address[31:4] == MMIO_BASE[31:4]);
  assign reg_sel      = mmio_reg_e'(Address[3:2]);
  assign unused_addr_lsbs = ^{PC[1:0], Address[1:0]};

  assign Instruction = fetch_hit ? ram_q[PC[ADDR_WIDTH+1:2]] : 32'h0;

  // Byte-lane writes; reads are combinational so a same-cycle read sees the old word.
  always_ff @(posedge clk) begin
    if (MemWrite && data_ram_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (Write_strb[i]) ram_q[Address[ADDR_WIDTH+1:2]][8*i +: 8] <= Write_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    console_wr = MemWrite && mmio_hit && (reg_sel == RegConsole) && Write_strb[0];
    drops_clr  = MemWrite && mmio_hit && (reg_sel == RegDrops);
    pop        = tx_valid && tx_ready;
    push       = console_wr && (!fifo_full || pop);
    drop       = console_wr && fifo_full && !pop;
    cycle_d    = cycle_q + 32'd1;
    drops_d    = drops_q;
    if (drops_clr) begin
      drops_d = '0;
    end else if (drop && (drops_q != '1)) begin
      drops_d = drops_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_q <= '0;
      drops_q <= '0;
    end else begin
      cycle_q <= cycle_d;
      drops_q <= drops_d;
    end
  end

  tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push),
    .data_i  (Write_data[7:0]),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count),
    .head_o  (fifo_head)
  );

  assign tx_valid = !fifo_empty;
  assign tx_data  = fifo_head;

  assign count_ext  = 32'(fifo_count);
  assign status_cnt = (count_ext > 32'd7) ? 3'd7 : count_ext[2:0];

  always_comb begin
    Read_data = 32'h0;
    if (MemRead) begin
      if (data_ram_hit) begin
        Read_data = ram_q[Address[ADDR_WIDTH+1:2]];
      end else if (mmio_hit) begin
        unique case (reg_sel)
          RegCycle:   Read_data = cycle_q;
          RegConsole: Read_data = 32'h0;
          RegStatus:  Read_data = status_word(status_cnt, fifo_empty, fifo_full);
          RegDrops:   Read_data = drops_q;
          default:    Read_data = 32'h0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder: RAM byte writes, decode, MMIO counters and console FIFO.
module tb_cpu_mem_responder;

  localparam logic [31:0] ACycle   = 32'h8000_0000;
  localparam logic [31:0] AConsole = 32'h8000_0004;
  localparam logic [31:0] AStatus  = 32'h8000_0008;
  localparam logic [31:0] ADrops   = 32'h8000_000C;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] PC = '0;
  logic [31:0] Instruction;
  logic [31:0] Address = '0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] Write_data = '0;
  logic [3:0]  Write_strb = '0;
  logic [31:0] Read_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  cpu_mem_responder dut (
    .clk         (clk),
    .rst         (rst),
    .PC          (PC),
    .Instruction (Instruction),
    .Address     (Address),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .Write_data  (Write_data),
    .Write_strb  (Write_strb),
    .Read_data   (Read_data),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    Write_strb = '0;
    Write_data = '0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    MemWrite = 1'b0;
    MemRead  = 1'b1;
    Address  = a;
    #1;
    d = Read_data;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    MemRead    = 1'b0;
    MemWrite   = 1'b1;
    Address    = a;
    Write_data = d;
    Write_strb = s;
  endtask

  initial begin
    logic [31:0] v;
    #1 rst = 1'b1;
    #2;
    check_eq("rst_tx_valid", 32'(tx_valid), 32'h0);
    check_eq("rst_tx_data", 32'(tx_data), 32'h0);
    rd(ACycle, v);  check_eq("rst_cycle", v, 32'h0);
    rd(AStatus, v); check_eq("rst_status", v, 32'h2);
    rd(ADrops, v);  check_eq("rst_drops", v, 32'h0);

    // Cycle counter
    step();
    rst = 1'b0;
    repeat (5) step();
    rd(ACycle, v); check_eq("cycle_5", v, 32'd5);
    force dut.cycle_q = 32'hFFFF_FFFF;
    rd(ACycle, v); check_eq("cycle_forced", v, 32'hFFFF_FFFF);
    release dut.cycle_q;
    step();
    rd(ACycle, v); check_eq("cycle_wrap", v, 32'h0);

    // RAM byte writes
    wr(32'h0, 32'h1111_1111, 4'hF); step();
    wr(32'h10, 32'hDEAD_BEEF, 4'hF); step();
    wr(32'h10, 32'h0000_00AA, 4'h1); MemRead = 1'b1; #1;
    check_eq("same_cycle_old", Read_data, 32'hDEAD_BEEF);
    step();
    rd(32'h10, v); check_eq("byte_merge", v, 32'hDEAD_BEAA);
    wr(32'h10, 32'hFFFF_FFFF, 4'h0); step();
    rd(32'h10, v); check_eq("strb_zero", v, 32'hDEAD_BEAA);
    MemRead = 1'b0; #1;
    check_eq("rd_disabled", Read_data, 32'h0);

    // Fetch and unmapped decode
    step();
    PC = 32'h10;        #1; check_eq("fetch_10", Instruction, 32'hDEAD_BEAA);
    PC = 32'h4000_0000; #1; check_eq("fetch_unmapped", Instruction, 32'h0);
    PC = 32'h0;         #1; check_eq("fetch_0", Instruction, 32'h1111_1111);
    wr(32'h4000_0000, 32'h1234_5678, 4'hF); step();
    rd(32'h4000_0000, v); check_eq("rd_unmapped", v, 32'h0);
    rd(32'h0, v);         check_eq("no_alias_write", v, 32'h1111_1111);
    rd(32'h8000_0010, v); check_eq("past_mmio_window", v, 32'h0);
    rd(AConsole, v);      check_eq("console_reads_0", v, 32'h0);

    // Fill FIFO with sink stalled, one extra push drops
    step();
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr(AConsole, 32'h41 + i, 4'h1);
      if (i == 0) begin
        #1; check_eq("no_bypass", 32'(tx_valid), 32'h0);
      end
      step();
      if (i == 0) check_eq("valid_next_cycle", 32'(tx_valid), 32'h1);
    end
    rd(AStatus, v); check_eq("status_full", v, 32'h11);
    rd(ADrops, v);  check_eq("drops_1", v, 32'h1);
    step();
    check_eq("stall_stable", 32'(tx_data), 32'h41);
    idle();
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq("drain_data", 32'(tx_data), 32'h41 + i);
      step();
    end
    tx_ready = 1'b0;
    check_eq("drained_valid", 32'(tx_valid), 32'h0);
    rd(AStatus, v); check_eq("status_empty", v, 32'h2);

    // Push while full and popping: no drop
    for (int i = 0; i < 4; i++) begin
      wr(AConsole, 32'h51 + i, 4'h1); step();
    end
    wr(AConsole, 32'h55, 4'h1);
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    rd(AStatus, v); check_eq("full_push_pop_status", v, 32'h11);
    rd(ADrops, v);  check_eq("full_push_pop_nodrop", v, 32'h1);
    idle();
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq("drain2_data", 32'(tx_data), 32'h52 + i);
      step();
    end
    tx_ready = 1'b0;
    check_eq("drain2_empty", 32'(tx_valid), 32'h0);
    wr(ADrops, 32'h0, 4'h0); step();
    rd(ADrops, v); check_eq("drops_cleared", v, 32'h0);

    // Asynchronous reset mid-handshake
    step();
    for (int i = 0; i < 3; i++) begin
      wr(AConsole, 32'h61 + i, 4'h1); step();
    end
    idle(); #1;
    check_eq("pre_rst_valid", 32'(tx_valid), 32'h1);
    rst = 1'b1; #1;
    check_eq("rst_async_valid", 32'(tx_valid), 32'h0);
    check_eq("rst_async_data", 32'(tx_data), 32'h0);
    rd(32'h10, v); check_eq("ram_during_rst", v, 32'hDEAD_BEAA);
    step();
    step();
    rst = 1'b0;
    rd(AStatus, v); check_eq("post_rst_status", v, 32'h2);
    rd(ACycle, v);  check_eq("post_rst_cycle0", v, 32'h0);
    step();
    rd(ACycle, v);  check_eq("post_rst_cycle1", v, 32'h1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
